// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake (data/valid/ready) plus the serial line and busy flag of the UART transmitter.
interface uart_tx_ctrl_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       busy;

    modport master (
        output data,
        output valid,
        input  ready,
        input  tx,
        input  busy
    );

    modport slave (
        input  data,
        input  valid,
        output ready,
        output tx,
        output busy
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: start bit, 8 data bits LSB first, stop bit; one byte per frame via valid/ready.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_ctrl #(
    parameter int unsigned CLK_DIV = 102
) (
    input  logic          CLKIN,
    input  logic          RESET,
    uart_tx_ctrl_if.slave bus
);

    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t      state_q;
    logic [15:0] baud_q;
    logic [15:0] baud_d;
    logic [2:0]  idx_q;
    logic [2:0]  idx_d;
    logic [7:0]  data_q;
    logic        tx_q;
    logic        ready_q;
    logic        busy_q;
    logic        baud_last;

    assign baud_last = (baud_q == BAUD_LAST);
    assign baud_d    = baud_last ? 16'd0 : baud_q + 16'd1;
    // Wraps 7->0 on the last data bit, so the index is already clear for the next frame.
    assign idx_d     = idx_q + 3'd1;

    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            baud_q  <= 16'd0;
            idx_q   <= 3'd0;
            data_q  <= 8'h00;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    baud_q <= 16'd0;
                    if (bus.valid) begin
                        data_q  <= bus.data;
                        idx_q   <= 3'd0;
                        state_q <= S_START;
                        tx_q    <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end

                S_START: begin
                    baud_q <= baud_d;
                    if (baud_last) begin
                        state_q <= S_DATA;
                        tx_q    <= data_q[0];
                    end
                end

                S_DATA: begin
                    baud_q <= baud_d;
                    if (baud_last) begin
                        idx_q <= idx_d;
                        if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= S_PARITY;
                            tx_q    <= ^data_q;
`else
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            tx_q <= data_q[idx_d];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    baud_q <= baud_d;
                    if (baud_last) begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                    end
                end
`endif

                // The extra idle cycle after this state stretches the stop bit to CLK_DIV+1.
                S_STOP: begin
                    baud_q <= baud_d;
                    if (baud_last) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    baud_q  <= 16'd0;
                    idx_q   <= 3'd0;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx    = tx_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 102: number of CLKIN cycles per serial bit; legal range 2..65535.
REQ-002 SHALL provide port CLKIN  input  1  single clock, all state updates on its rising edge.
REQ-003 SHALL provide port RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port data  input  8  byte to transmit, sampled only on acceptance.
REQ-005 SHALL provide port valid  input  1  requester has a byte on data.
REQ-006 SHALL provide port ready  output  1  block can accept a byte this cycle.
REQ-007 SHALL provide port tx  output  1  serial line, idle high.
REQ-008 SHALL provide port busy  output  1  frame in progress; equals the inverse of ready.

Function
REQ-009 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP, with all outputs registered.
REQ-010 SHALL accept a byte on any rising edge with valid=1 and ready=1, at edge N: latch data, clear the bit counter, enter START, drive tx=0 and ready=0.
REQ-011 SHALL ignore valid and data whenever ready=0, with no queuing.
REQ-012 SHALL use a 16-bit baud counter counting 0..CLK_DIV-1, cleared on acceptance, so each bit lasts exactly CLK_DIV cycles.
REQ-013 SHALL drive tx=data[k] from edge N+(k+1)*CLK_DIV, for k=0..7, LSB first, using a 3-bit index that wraps 7->0 when leaving DATA.
REQ-014 SHALL enter STOP with tx=1 at edge N+9*CLK_DIV when the macro is absent.
REQ-015 SHALL return to IDLE with ready=1 at edge N+10*CLK_DIV, so the stop bit lasts at least CLK_DIV+1 cycles.
REQ-016 SHALL accept a held valid on the first edge after ready rises, giving back-to-back frames with exactly one extra stop cycle.
REQ-017 SHALL not change tx in IDLE (held 1) regardless of valid/data toggling.

Reset
REQ-018 SHALL, on RESET=1 (asynchronous, including mid-frame), force state=IDLE, tx=1, ready=1, busy=0, baud counter=0, bit index=0, and the data register=0.
REQ-019 SHALL remain in IDLE while RESET=1, and accept no byte on any edge where RESET is high.
REQ-020 SHALL allow acceptance on the first rising edge after RESET falls.

Configuration
REQ-021 SHALL compile an even-parity bit in if and only if macro UART_TX_PARITY_EN is defined.
REQ-022 SHALL, with UART_TX_PARITY_EN defined, enter PARITY at edge N+9*CLK_DIV, driving tx=XOR of the latched data bits for CLK_DIV cycles, then STOP at N+10*CLK_DIV and IDLE at N+11*CLK_DIV.
REQ-023 SHALL, without UART_TX_PARITY_EN, contain no PARITY state or parity logic and follow the 10-bit frame timing.

Verification (CLK_DIV=4 unless stated)
REQ-024 SHALL cover a single byte: accept 0xA5 at edge N -> tx=0 for N..N+3; bits 1,0,1,0,0,1,0,1 each 4 cycles; tx=1 from N+36; ready=1 at N+40.
REQ-025 SHALL cover back-to-back frames: valid held with 0x00 then 0xFF -> second start bit at N+41; tx high for exactly 5 cycles between frames.
REQ-026 SHALL cover ignored input: toggle data to 0x3C and pulse valid during DATA of a 0x81 frame -> waveform matches 0x81 only, with no second frame.
REQ-027 SHALL cover reset mid-frame: assert RESET at N+17 -> tx=1 and ready=1 without waiting for an edge; after release, 0x55 transmits with correct timing.
REQ-028 SHALL cover parity with UART_TX_PARITY_EN: 0x07 -> parity bit tx=1 at N+36..N+39, stop at N+40, ready at N+44; 0x03 -> parity tx=0.
REQ-029 SHALL cover minimum divider CLK_DIV=2, byte 0xFF -> start 2 cycles, frame length 20 cycles, ready at N+20.
